countdown_sequencer: RTL

COUNTDOWN_SEQUENCER -- requirements
Module: countdown_sequencer

---
 rtl/countdown_sequencer_pkg.sv | 19 +
 rtl/countdown_sequencer_if.sv | 27 ++
 rtl/countdown_sequencer_down_counter_core.sv | 29 ++
 rtl/countdown_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/countdown_sequencer_pkg.sv
// Shared types and constants for the countdown sequencer slice.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN (DONE reloads and re-enters RUN).
package countdown_sequencer_pkg;

  // Sequencer states; DONE lasts exactly one cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // Default counter width in bits.
  localparam int WIDTH_DEFAULT = 5;

  // Start value used when a start is accepted with load_val == 0.
  localparam int DEFAULT_LOAD_VALUE = 9;

endpackage

// File: rtl/countdown_sequencer_if.sv
// Control/status bundle of the countdown sequencer.
// master drives the controls, slave (the sequencer) drives the status.
interface countdown_sequencer_if
  import countdown_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             start;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start, pause, abort, load_val,
    input  count, busy, done
  );

  modport slave (
    input  start, pause, abort, load_val,
    output count, busy, done
  );

endinterface

// File: rtl/countdown_sequencer_down_counter_core.sv
// Counter datapath: synchronous load, saturating decrement (never wraps below 0).
// State changes on the falling edge of clk; clr_n clears asynchronously.
module down_counter_core #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Load has priority over decrement; a zero count stays at zero.
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/countdown_sequencer.sv
// Countdown sequencer: IDLE/RUN/HOLD/DONE FSM plus reload register,
// driving a down_counter_core. All state changes on the falling clk edge.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN -- when defined, DONE
// reloads the count from the reload register and returns to RUN.
module countdown_sequencer
  import countdown_sequencer_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEFAULT,
  parameter int DEFAULT_LOAD = DEFAULT_LOAD_VALUE
) (
  input  logic                 clk,
  input  logic                 clr_n,
  countdown_sequencer_if.slave bus
);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_reload;

  logic             w_load;
  logic             w_en;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_start_val;

  // A zero load value selects the built-in default start value.
  assign w_start_val = (bus.load_val == '0) ? WIDTH'(DEFAULT_LOAD) : bus.load_val;

  // Counter control: abort zeroes the count, accepted start loads it,
  // RUN without pause decrements, DONE optionally reloads.
  always_comb begin
    w_load     = 1'b0;
    w_en       = 1'b0;
    w_load_val = '0;
    if (bus.abort) begin
      w_load     = 1'b1;
      w_load_val = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!bus.pause && bus.start) begin
            w_load     = 1'b1;
            w_load_val = w_start_val;
          end
        end
        RUN: begin
          w_en = !bus.pause;
        end
        DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          w_load     = 1'b1;
          w_load_val = r_reload;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  down_counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clk),
    .clr_n      (clr_n),
    .i_load     (w_load),
    .i_en       (w_en),
    .i_load_val (w_load_val),
    .o_count    (w_count)
  );

  // FSM with registered busy/done and the reload register; abort > pause > start.
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_reload <= '0;
    end else if (bus.abort) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (!bus.pause && bus.start) begin
            r_reload <= w_start_val;
            r_state  <= RUN;
            r_busy   <= 1'b1;
          end
        end
        RUN: begin
          if (bus.pause) begin
            r_state <= HOLD;
          end else if (w_count <= WIDTH'(1)) begin
            // Count reaches 0 on this same edge.
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        HOLD: begin
          // Leaving HOLD costs one edge with no decrement.
          if (!bus.pause) begin
            r_state <= RUN;
          end
        end
        DONE: begin
          // pause is ignored here: DONE always lasts one cycle.
          r_done <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          r_state <= RUN;
          r_busy  <= 1'b1;
`else
          r_state <= IDLE;
          r_busy  <= 1'b0;
`endif
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifndef COUNTDOWN_AUTO_RELOAD_EN
  // The reload value is only consumed by the auto-reload build.
  logic w_unused_reload;
  assign w_unused_reload = ^r_reload;
`endif

  assign bus.count = w_count;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule
